traffic_display: RTL and testbench
==================================

# traffic_display

Downstream display stage for `trafficlight`. It consumes the two 6-bit countdown values `A_time` and `B_time` and drives a 4-digit multiplexed common-anode seven-segment display:
- digits 3..2 show road A seconds;
- digits 1..0 show road B seconds.

It takes a tear-free snapshot of both values once per scan frame, converts them to two decimal digits each, blanks leading zeros, and blinks a road's digits when its countdown is nearly expired.

## Interface

Parameters:
- `SCAN_DIV`, 50000: CLK cycles each digit stays enabled; legal range ≥ 2.
- `BLINK_FRAMES`, 64: scan frames per blink half-period; legal range ≥ 1.
- `BLINK_TH`, 3: a road blinks when its snapshot value is 1..`BLINK_TH`.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `A_time`  in  6  road A remaining seconds, 0..63, synchronous to `CLK`.
- `B_time`  in  6  road B remaining seconds, 0..63.
- `an`  out  4  digit enables, active-low; `an[3]`=A tens, `an[2]`=A units, `an[1]`=B tens, `an[0]`=B units.
- `seg`  out  8  segments, active-high; `seg[0..6]`=a..g, `seg[7]`=dp, which is always 0.

## Operation

Internal state:
- Scan counter `cnt` counts 0..`SCAN_DIV`-1.
- Digit index `idx` counts 0..3.
- A frame is the 4×`SCAN_DIV` cycles from `idx`=0,`cnt`=0 to `idx`=3,`cnt`=`SCAN_DIV`-1.

Digit advance:
- When `cnt`=`SCAN_DIV`-1, `cnt` returns to 0 and `idx` advances 0→1→2→3→0.
- Otherwise `cnt` increments and `idx` holds.

Snapshot:
- `snapA`/`snapB` load `A_time`/`B_time` on the frame-end cycle (`idx`=3, `cnt`=`SCAN_DIV`-1).
- Input changes inside a frame are invisible until the next frame.

Frame and blink counters:
- The frame counter increments on the frame-end cycle and wraps at `BLINK_FRAMES`-1.
- On that wrap, the blink phase `ph` toggles.

Digit decode (per road, value v = snapshot):
- tens = v/10, units = v%10. Tens is 0..6.
- Decode uses compare/subtract; no divider.

Segment patterns:
- Digits 0..9 map to 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- Blank = 00.

Leading-zero blanking: tens digit = 0 displays blank. Units always display, so v=0 shows " 0".

Blink rule:
- Applies when 1 ≤ v ≤ `BLINK_TH` and `ph`=1.
- Both digits of that road output `seg`=00, while `an` still scans normally.
- v=0 never blinks. Roads are evaluated independently.

Output mapping:
- `an` = 0111, 1011, 1101, 1110 for `idx` 0, 1, 2, 3.
- `seg` = the pattern of the digit selected by `idx`.

## Timing

Reset (`RST` high at a CLK edge) sets:
- `cnt`=0, `idx`=0, `snapA`=`snapB`=0;
- frame counter = 0, `ph`=0;
- `an`=1111 (all digits off), `seg`=00.

Reset is synchronous and wins over all other updates, including mid-frame. No residual digit may be enabled on the edge that samples `RST`=1.

Output latency:
- `an` and `seg` are registered and reflect `idx`/snapshot with 1-cycle latency.
- First edge after `RST` falls: `an`=0111, `seg`=blank (snapA=0, tens blank).

Snapshot visibility:
- The snapshot loaded at a frame end is first visible on the `seg` of the first cycle of the next frame.
- Exactly one `an` bit is low at any time outside reset.
- `an` and `seg` change on the same edge, so there is no ghosting cycle with the wrong pattern.

Frame length: 4×`SCAN_DIV` cycles.

Blink half-period: `BLINK_FRAMES`×4×`SCAN_DIV` cycles.

## Test plan

All scenarios use `SCAN_DIV`=2, `BLINK_FRAMES`=2, `BLINK_TH`=3, 10 ns clock.

- **Reset:** hold `RST`=1 for 3 cycles. Required: `an`=1111, `seg`=00 throughout. First edge after release gives `an`=0111, `seg`=00. `an` then steps 1011, 1101, 1110 every 2 cycles.
- **Steady values:** `A_time`=25, `B_time`=7. In the second frame, `seg` is 5B, 6D, 00, 07, each held 2 cycles, with `an` 0111, 1011, 1101, 1110.
- **Mid-frame change:** change `A_time` 25→24 while `idx`=1. Required: the current frame still shows 6D, and the next frame's `an[2]` slot shows 66.
- **Extremes:** `A_time`=63, `B_time`=0. Required: 7D, 4F, 00, 3F, and no blinking on B.
- **Blink:** `A_time`=3, `B_time`=40. Required: A slots show `seg`=00 in frames where `ph`=1 (2 frames on, 2 frames off) and 00, 4F where `ph`=0. B slots always show 66, 3F. Setting `A_time`=4 stops the blink from the next frame.
- **Reset mid-operation:** assert `RST` for 1 cycle while `idx`=2. Required: next edge gives `an`=1111, `seg`=00, and the snapshot is cleared. Scanning restarts at `an`=0111 showing blank/"0" until the first new frame end.

Source files
------------

// File: rtl/traffic_display.sv
`default_nettype none
// ============================================================================
// Module      : traffic_display
// Description : Four-digit multiplexed common-anode seven-segment driver for
//               the two traffic-light countdowns. Digits 3..2 show road A and
//               digits 1..0 show road B. Both values are captured once per scan
//               frame so the display never tears. Leading zeros are blanked,
//               and a road's digits blink while its countdown is 1..BLINK_TH.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int BLINK_TH     = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] A_time,
    input  logic [5:0] B_time,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [5:0]         r_snap_a;
    logic [5:0]         r_snap_b;
    logic [c_FRM_W-1:0] r_frm;
    logic               r_ph;

    logic               w_cnt_last;
    logic               w_frame_end;
    logic [3:0]         w_a_tens, w_a_units, w_b_tens, w_b_units;
    logic               w_blink_a, w_blink_b;
    logic [3:0]         w_an_nxt;
    logic [7:0]         w_seg_nxt;

    // Split a 0..63 value into tens and units with compares and one subtract.
    function automatic logic [7:0] f_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] sub;
        logic [5:0] u;
        if      (v >= 6'd60) begin t = 4'd6; sub = 6'd60; end
        else if (v >= 6'd50) begin t = 4'd5; sub = 6'd50; end
        else if (v >= 6'd40) begin t = 4'd4; sub = 6'd40; end
        else if (v >= 6'd30) begin t = 4'd3; sub = 6'd30; end
        else if (v >= 6'd20) begin t = 4'd2; sub = 6'd20; end
        else if (v >= 6'd10) begin t = 4'd1; sub = 6'd10; end
        else                 begin t = 4'd0; sub = 6'd0;  end
        u = v - sub;
        return {t, u[3:0]};
    endfunction

    // Segment pattern (dp always off) for one decimal digit.
    function automatic logic [7:0] f_seg(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    assign w_cnt_last  = (r_cnt == c_CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_cnt_last && (r_idx == 2'd3);

    assign {w_a_tens, w_a_units} = f_bcd(r_snap_a);
    assign {w_b_tens, w_b_units} = f_bcd(r_snap_b);

    assign w_blink_a = r_ph && (r_snap_a != 6'd0) && (int'(r_snap_a) <= BLINK_TH);
    assign w_blink_b = r_ph && (r_snap_b != 6'd0) && (int'(r_snap_b) <= BLINK_TH);

    // Scan position: dwell SCAN_DIV cycles per digit, then move to the next.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_cnt_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Frame-end snapshot plus frame counter driving the blink phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_snap_a <= 6'd0;
            r_snap_b <= 6'd0;
            r_frm    <= '0;
            r_ph     <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_a <= A_time;
            r_snap_b <= B_time;
            if (r_frm == c_FRM_W'(BLINK_FRAMES - 1)) begin
                r_frm <= '0;
                r_ph  <= ~r_ph;
            end else begin
                r_frm <= r_frm + c_FRM_W'(1);
            end
        end
    end

    // Select the enable and pattern for the digit currently being scanned.
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 8'h00;
        case (r_idx)
            2'd0: begin
                w_an_nxt  = 4'b0111;
                w_seg_nxt = (w_blink_a || w_a_tens == 4'd0) ? 8'h00 : f_seg(w_a_tens);
            end
            2'd1: begin
                w_an_nxt  = 4'b1011;
                w_seg_nxt = w_blink_a ? 8'h00 : f_seg(w_a_units);
            end
            2'd2: begin
                w_an_nxt  = 4'b1101;
                w_seg_nxt = (w_blink_b || w_b_tens == 4'd0) ? 8'h00 : f_seg(w_b_tens);
            end
            default: begin
                w_an_nxt  = 4'b1110;
                w_seg_nxt = w_blink_b ? 8'h00 : f_seg(w_b_units);
            end
        endcase
    end

    // Register enable and pattern together so they always switch on one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            an  <= 4'b1111;
            seg <= 8'h00;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_display
// Description : Self-checking bench for traffic_display with SCAN_DIV=2,
//               BLINK_FRAMES=2, BLINK_TH=3. Each output frame is 8 cycles;
//               slot s (2 cycles each) must show an = ~(1000 >> s).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_display;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] A_time = 6'd0;
    logic [5:0] B_time = 6'd0;
    logic [3:0] an;
    logic [7:0] seg;

    int n_chk  = 0;
    int n_pass = 0;
    int f      = 0;   // output frame index since last reset release

    typedef struct {
        logic [5:0]      a;
        logic [5:0]      b;
        logic [0:3][7:0] ex;
    } vec_t;

    vec_t            tbl [7];
    logic [0:3][7:0] prev;
    logic [0:3][7:0] zeros_ex;

    traffic_display #(
        .SCAN_DIV    (2),
        .BLINK_FRAMES(2),
        .BLINK_TH    (3)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .A_time(A_time),
        .B_time(B_time),
        .an    (an),
        .seg   (seg)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and compare both outputs 1 ns after the edge.
    task automatic tick(input logic [3:0] ea, input logic [7:0] es, input string nm);
        @(posedge CLK);
        #1;
        n_chk++;
        if (an === ea && seg === es) n_pass++;
        else $display("FAIL %s (frame %0d): an=%b seg=%h, expected an=%b seg=%h",
                      nm, f, an, seg, ea, es);
    endtask

    task automatic slot(input int i, input logic [0:3][7:0] ex, input string nm);
        logic [3:0] ea;
        ea = ~(4'b1000 >> (i / 2));
        tick(ea, ex[i/2], nm);
    endtask

    task automatic check_frame(input logic [0:3][7:0] ex, input string nm);
        for (int i = 0; i < 8; i++) slot(i, ex, nm);
        f++;
    endtask

    // Road A = 3, road B = 40: A blanks entirely while the phase is high.
    function automatic logic [0:3][7:0] blink_ex(input int fr);
        logic [0:3][7:0] e;
        e = ((fr >> 1) & 1) != 0 ? {8'h00, 8'h00, 8'h66, 8'h3F}
                                 : {8'h00, 8'h4F, 8'h66, 8'h3F};
        return e;
    endfunction

    initial begin
        tbl[0] = '{a: 6'd25, b: 6'd7,  ex: {8'h5B, 8'h6D, 8'h00, 8'h07}};
        tbl[1] = '{a: 6'd63, b: 6'd0,  ex: {8'h7D, 8'h4F, 8'h00, 8'h3F}};
        tbl[2] = '{a: 6'd40, b: 6'd10, ex: {8'h66, 8'h3F, 8'h06, 8'h3F}};
        tbl[3] = '{a: 6'd9,  b: 6'd59, ex: {8'h00, 8'h6F, 8'h6D, 8'h6F}};
        tbl[4] = '{a: 6'd0,  b: 6'd0,  ex: {8'h00, 8'h3F, 8'h00, 8'h3F}};
        tbl[5] = '{a: 6'd30, b: 6'd61, ex: {8'h4F, 8'h3F, 8'h7D, 8'h06}};
        tbl[6] = '{a: 6'd19, b: 6'd20, ex: {8'h06, 8'h6F, 8'h5B, 8'h3F}};
        zeros_ex = {8'h00, 8'h3F, 8'h00, 8'h3F};

        // Reset held for three edges: all digits off.
        A_time = tbl[0].a;
        B_time = tbl[0].b;
        for (int i = 0; i < 3; i++) tick(4'b1111, 8'h00, "reset_hold");
        RST = 1'b0;

        // First frame still shows the cleared snapshot " 0  0".
        check_frame(zeros_ex, "first_frame");

        // Table: each frame shows the values applied during the previous one.
        prev = tbl[0].ex;
        for (int i = 1; i < 7; i++) begin
            A_time = tbl[i].a;
            B_time = tbl[i].b;
            check_frame(prev, "table");
            prev = tbl[i].ex;
        end

        // Mid-frame change of A is invisible until the next frame.
        A_time = 6'd25;
        B_time = 6'd7;
        check_frame(prev, "table_last");
        for (int i = 0; i < 3; i++) slot(i, tbl[0].ex, "midframe_before");
        A_time = 6'd24;
        for (int i = 3; i < 8; i++) slot(i, tbl[0].ex, "midframe_after");
        f++;
        check_frame({8'h5B, 8'h66, 8'h00, 8'h07}, "midframe_next");

        // Blink: A=3 blinks with 2 frames on / 2 frames off; B=40 steady.
        A_time = 6'd3;
        B_time = 6'd40;
        check_frame({8'h5B, 8'h66, 8'h00, 8'h07}, "blink_enter");
        for (int k = 0; k < 4; k++) check_frame(blink_ex(f), "blink");
        // Make the frame after A=4 a phase-high frame to prove blinking stops.
        while (((f + 1) >> 1 & 1) == 0) check_frame(blink_ex(f), "blink_align");
        A_time = 6'd4;
        check_frame(blink_ex(f), "blink_last");
        check_frame({8'h00, 8'h66, 8'h66, 8'h3F}, "blink_stop");

        // Reset for one cycle while idx = 2.
        A_time = 6'd25;
        B_time = 6'd7;
        for (int i = 0; i < 5; i++) slot(i, {8'h00, 8'h66, 8'h66, 8'h3F}, "prereset");
        RST = 1'b1;
        tick(4'b1111, 8'h00, "reset_mid");
        RST = 1'b0;
        f = 0;
        check_frame(zeros_ex, "post_reset_cleared");
        check_frame(tbl[0].ex, "post_reset_new");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
